// File: rtl/rj45_serial_rx_if.sv
// Avalon-ST style sample stream carried out of the RJ45 serial receiver.
interface rj45_serial_rx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_WIDTH   = 4
);
  logic [DATA_WIDTH-1:0] mic_output_data;
  logic [CH_WIDTH-1:0]   mic_output_channel;
  logic [1:0]            mic_output_error;
  logic                  mic_output_valid;

  modport master (
    output mic_output_data,
    output mic_output_channel,
    output mic_output_error,
    output mic_output_valid
  );

  modport slave (
    input mic_output_data,
    input mic_output_channel,
    input mic_output_error,
    input mic_output_valid
  );
endinterface

// File: rtl/rj45_serial_rx.sv
// RJ45 mic link receiver: synchronizes the serial clock/data, locks onto the
// frame sync word and emits channelized samples as an Avalon-ST source.
module rj45_serial_rx #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          N_CHANNELS     = 16,
  parameter int          CH_WIDTH       = 4,
  parameter logic [15:0] SYNC_WORD      = 16'hF0A5,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   serial_clk_in,
  input  logic                   serial_data_in,
  rj45_serial_rx_if.master       mic,
  output logic                   frame_locked,
  output logic [7:0]             sync_loss_count
);

  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BIT_W-1:0]    LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]    LAST_SYNC = BIT_W'(15);
  localparam logic [CH_WIDTH-1:0] LAST_CH   = CH_WIDTH'(N_CHANNELS - 1);
  localparam logic [IDLE_W-1:0]   IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {HUNT, WORD, SYNC_CHK} state_t;

  logic clk_s1, clk_s2, clk_s3, data_s1, data_s2;
  logic strobe, bit_in;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {clk_s1, clk_s2, clk_s3} <= '0;
      {data_s1, data_s2}       <= '0;
    end else begin
      clk_s1  <= serial_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= serial_data_in;
      data_s2 <= data_s1;
    end
  end

  assign strobe = clk_s2 & ~clk_s3;
  assign bit_in = data_s2;

  state_t                state_q, state_d;
  logic [15:0]           hunt_q, hunt_d, hunt_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic                  resync_q, resync_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [7:0]            loss_q, loss_d, loss_inc;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_WIDTH-1:0]   chan_q, chan_d;
  logic [1:0]            err_q, err_d;
  logic                  valid_q, valid_d;

  assign hunt_next = {hunt_q[14:0], bit_in};
  assign shifted   = {shift_q[DATA_WIDTH-2:0], bit_in};
  assign loss_inc  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

  always_comb begin
    // NOTE: every next-value signal gets its hold value first so no path
    // through the case leaves it unassigned (which would infer a latch).
    state_d   = state_q;
    hunt_d    = hunt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ch_d      = ch_q;
    resync_d  = resync_q;
    loss_d    = loss_q;
    data_d    = data_q;
    chan_d    = chan_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    idle_d    = strobe ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1);

    if (strobe) begin
      unique case (state_q)
        HUNT: begin
          hunt_d = hunt_next;
          if (hunt_next == SYNC_WORD) begin
            state_d   = WORD;
            bit_cnt_d = '0;
            ch_d      = '0;
            resync_d  = 1'b1;
          end
        end
        WORD: begin
          shift_d = shifted;
          if (bit_cnt_q == LAST_BIT) begin
            data_d    = shifted;
            chan_d    = ch_q;
            err_d     = {1'b0, (ch_q == '0) && resync_q};
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            if (ch_q == '0) resync_d = 1'b0;
            if (ch_q == LAST_CH) begin
              ch_d    = '0;
              state_d = SYNC_CHK;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        SYNC_CHK: begin
          shift_d = shifted;
          if (bit_cnt_q == LAST_SYNC) begin
            bit_cnt_d = '0;
            if (shifted[15:0] == SYNC_WORD) begin
              state_d = WORD;
              ch_d    = '0;
            end else begin
              state_d = HUNT;
              hunt_d  = '0;
              loss_d  = loss_inc;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT && idle_q == IDLE_MAX) begin
      // Link went quiet mid-frame: drop the partial word and start hunting.
      state_d   = HUNT;
      hunt_d    = '0;
      bit_cnt_d = '0;
      ch_d      = '0;
      loss_d    = loss_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      hunt_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ch_q      <= '0;
      resync_q  <= 1'b0;
      idle_q    <= '0;
      loss_q    <= '0;
      data_q    <= '0;
      chan_q    <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hunt_q    <= hunt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ch_q      <= ch_d;
      resync_q  <= resync_d;
      idle_q    <= idle_d;
      loss_q    <= loss_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  assign mic.mic_output_data    = data_q;
  assign mic.mic_output_channel = chan_q;
  assign mic.mic_output_error   = err_q;
  assign mic.mic_output_valid   = valid_q;
  assign frame_locked           = (state_q != HUNT);
  assign sync_loss_count        = loss_q;

endmodule

// File: tb/tb_rj45_serial_rx.sv
// Randomized bench for rj45_serial_rx: a bit-stream frame model feeds a
// scoreboard queue that an independent monitor drains on every valid.
module tb_rj45_serial_rx;
  localparam int          DW   = 32;
  localparam int          NCH  = 16;
  localparam int          CHW  = 4;
  localparam int          TO   = 32;
  localparam logic [15:0] SYNC = 16'hF0A5;
  localparam int          FRAME_BITS = NCH * DW;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_clk_in = 1'b0;
  logic       serial_data_in = 1'b0;
  logic       frame_locked;
  logic [7:0] sync_loss_count;

  rj45_serial_rx_if #(.DATA_WIDTH(DW), .CH_WIDTH(CHW)) mic ();

  rj45_serial_rx #(
    .DATA_WIDTH(DW), .N_CHANNELS(NCH), .CH_WIDTH(CHW),
    .SYNC_WORD(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .serial_clk_in  (serial_clk_in),
    .serial_data_in (serial_data_in),
    .mic            (mic.master),
    .frame_locked   (frame_locked),
    .sync_loss_count(sync_loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  data;
    logic [CHW-1:0] ch;
    logic [1:0]     err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   half  = 40;

  // Frame model: position counted in bits since the last accepted sync.
  bit          m_locked, m_first;
  logic [15:0] m_win, m_sync;
  logic [31:0] m_word;
  int          m_pos, m_loss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_locked = 0; m_first = 0; m_win = '0; m_sync = '0;
    m_word = '0; m_pos = 0; m_loss = 0;
    exp_q.delete();
  endfunction

  function automatic void model_lose();
    m_locked = 0;
    m_win    = '0;
    if (m_loss < 255) m_loss++;
  endfunction

  function automatic void model_bit(input bit b);
    exp_t e;
    if (!m_locked) begin
      m_win = {m_win[14:0], b};
      if (m_win == SYNC) begin
        m_locked = 1; m_pos = 0; m_first = 1;
      end
    end else if (m_pos < FRAME_BITS) begin
      m_word = {m_word[30:0], b};
      if (m_pos % DW == DW - 1) begin
        e.data = m_word;
        e.ch   = CHW'(m_pos / DW);
        e.err  = {1'b0, (m_pos / DW == 0) && m_first};
        if (m_pos / DW == 0) m_first = 0;
        exp_q.push_back(e);
      end
      m_pos++;
    end else begin
      m_sync = {m_sync[14:0], b};
      if (m_pos == FRAME_BITS + 15) begin
        if (m_sync == SYNC) m_pos = 0;
        else model_lose();
      end else begin
        m_pos++;
      end
    end
  endfunction

  task automatic send_bit(input bit b);
    serial_data_in = b;
    serial_clk_in  = 1'b0;
    #(half);
    serial_clk_in  = 1'b1;
    model_bit(b);
    #(half);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input bit fixed);
    for (int c = 0; c < NCH; c++)
      send_word(fixed ? 32'h0001_0000 + 32'(c) : $urandom, DW);
  endtask

  task automatic gap(input int cycles);
    serial_clk_in = 1'b0;
    #(cycles * 10);
    if (cycles > TO + 8 && m_locked) model_lose();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   mic.mic_output_data, 0);
    check({tag, "_chan"},   32'(mic.mic_output_channel), 0);
    check({tag, "_err"},    32'(mic.mic_output_error), 0);
    check({tag, "_valid"},  32'(mic.mic_output_valid), 0);
    check({tag, "_locked"}, 32'(frame_locked), 0);
    check({tag, "_loss"},   32'(sync_loss_count), 0);
  endtask

  always @(negedge clk) begin
    if (mic.mic_output_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got ch=%0d data=0x%0h, wanted no output at %0t",
                 mic.mic_output_channel, mic.mic_output_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sample_data",  mic.mic_output_data, e.data);
        check("sample_chan",  32'(mic.mic_output_channel), 32'(e.ch));
        check("sample_error", 32'(mic.mic_output_error), 32'(e.err));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got no finish, wanted finish before 3ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #22;
    check_all_zero("reset");
    reset_n = 1'b1;
    #20;

    // Lock and first frame with a known pattern.
    half = 40;
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    send_word(32'(SYNC), 16);
    check("locked_after_sync", 32'(frame_locked), 32'(m_locked));
    check("locked_is_set", 32'(frame_locked), 1);
    send_frame(1'b1);

    // Back-to-back frame behind a good sync.
    half = 30;
    send_word(32'(SYNC), 16);
    send_frame(1'b0);
    check("loss_after_continuous", 32'(sync_loss_count), 32'(m_loss));

    // Corrupted sync, then relock.
    send_word(32'hF0A4, 16);
    check("locked_after_bad_sync", 32'(frame_locked), 32'(m_locked));
    check("loss_after_bad_sync", 32'(sync_loss_count), 32'(m_loss));
    send_word(32'(SYNC), 16);
    send_frame(1'b0);

    // Link stall in the middle of channel 5.
    send_word(32'(SYNC), 16);
    for (int c = 0; c < 5; c++) send_word($urandom, DW);
    send_word($urandom, 10);
    gap(300);
    check("locked_after_timeout", 32'(frame_locked), 32'(m_locked));
    check("loss_after_timeout", 32'(sync_loss_count), 32'(m_loss));
    send_word(32'(SYNC), 16);
    send_frame(1'b1);

    // Reset in the middle of a word.
    send_word(32'(SYNC), 16);
    send_word($urandom, DW);
    send_word($urandom, 7);
    serial_clk_in = 1'b0;
    #30;
    reset_n = 1'b0;
    #30;
    check_all_zero("midreset");
    reset_n = 1'b1;
    model_reset();
    #30;
    send_word(32'(SYNC), 16);
    send_frame(1'b0);
    check("locked_after_relock", 32'(frame_locked), 32'(m_locked));

    // Drive the loss counter into saturation.
    for (int k = 0; k < 260; k++) begin
      send_word(32'(SYNC), 16);
      gap(TO + 12);
      if (k == 9) check("loss_midway", 32'(sync_loss_count), 32'(m_loss));
    end
    check("loss_saturated_model", 32'(sync_loss_count), 32'(m_loss));
    check("loss_saturated", 32'(sync_loss_count), 255);

    // Minimum serial period, data changing on the falling edge.
    half = 30;
    send_word(32'(SYNC), 16);
    for (int f = 0; f < 4; f++) begin
      send_frame(1'b0);
      send_word(32'(SYNC), 16);
    end
    check("locked_after_corner", 32'(frame_locked), 1);
    check("loss_after_corner", 32'(sync_loss_count), 255);

    #200;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
